// File: rtl/game_ctrl.sv
// game_ctrl: runner-game controller -- button conditioning, IDLE/RUN/DEAD FSM and score tick timing.
// Speed levels (shrinking tick period every 100 ticks) are built only when GAME_SPEEDUP_EN is defined.
module game_ctrl #(
  parameter int TICK_DIV  = 5_000_000,
  parameter int TICK_STEP = 250_000,
  parameter int TICK_MIN  = 1_500_000,
  parameter int DEB_LEN   = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_jump,
  input  logic       collide,
  output logic [1:0] gamestate,
  output logic       score_tick,
  output logic       score_clr,
  output logic       jump_pulse,
  output logic [3:0] speed_level
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEB_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DEAD = 2'b10, BAD = 2'b11} state_t;

  if (TICK_MIN < 1 || TICK_MIN > TICK_DIV || TICK_STEP < 0 || DEB_LEN < 1) begin : g_param_check
    $error("game_ctrl: need 1 <= TICK_MIN <= TICK_DIV, TICK_STEP >= 0, DEB_LEN >= 1");
  end

  logic          sync_p0, sync_p1;
  logic          stable, stable_q, press;
  logic [DW-1:0] deb_cnt;
  state_t        state, state_nx;
  logic [CW-1:0] tick_cnt, period;
  logic          enter_run, tick_wrap, tick_d, jump_d;

  // Stage p0/p1: two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_jump;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: stable follows sync_p1 only after DEB_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt  <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable;
      if (sync_p1 != stable) begin
        if (deb_cnt == DW'(DEB_LEN - 1)) begin
          stable  <= sync_p1;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = stable & ~stable_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (press)   state_nx = RUN;
      RUN:     if (collide) state_nx = DEAD;
      DEAD:    if (press)   state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Collide wins over a same-cycle press; a tick is dropped in the cycle RUN is left
  always_comb begin
    enter_run = (state != RUN) && (state_nx == RUN);
    tick_wrap = (state == RUN) && (tick_cnt == period - 1'b1);
    tick_d    = tick_wrap && (state_nx == RUN);
    jump_d    = press && (state == RUN) && !collide;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tick_cnt <= '0;
    else if (state != RUN)   tick_cnt <= '0;
    else if (tick_wrap)      tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef GAME_SPEEDUP_EN
  logic [6:0] lvl_ticks;
  logic [3:0] level;

  function automatic logic [3:0] sat_level_inc(input logic [3:0] l);
    return (l == 4'd15) ? l : l + 4'd1;
  endfunction

  function automatic logic [CW-1:0] calc_period(input logic [3:0] l);
    logic signed [33:0] p;
    p = $signed(34'(TICK_DIV)) - $signed(34'(l)) * $signed(34'(TICK_STEP));
    return (p < $signed(34'(TICK_MIN))) ? CW'(TICK_MIN) : CW'(p);
  endfunction

  // Level changes on the wrapping tick, so the new period applies from that wrap on
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_ticks <= '0;
      level     <= '0;
    end else if (enter_run) begin
      lvl_ticks <= '0;
      level     <= '0;
    end else if (tick_d) begin
      if (lvl_ticks == 7'd99) begin
        lvl_ticks <= '0;
        level     <= sat_level_inc(level);
      end else begin
        lvl_ticks <= lvl_ticks + 7'd1;
      end
    end
  end

  assign period      = calc_period(level);
  assign speed_level = level;
`else
  assign period      = CW'(TICK_DIV);
  assign speed_level = 4'd0;
`endif

  // Output registers: gamestate trails the internal state by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gamestate  <= 2'b00;
      score_tick <= 1'b0;
      score_clr  <= 1'b0;
      jump_pulse <= 1'b0;
    end else begin
      gamestate  <= state;
      score_tick <= tick_d;
      score_clr  <= enter_run;
      jump_pulse <= jump_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized scoreboard bench for game_ctrl with a cycle-level behavioural reference model.
module tb_game_ctrl;

  localparam int TD = 10;
  localparam int TS = 2;
  localparam int TM = 4;
  localparam int DL = 4;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DEAD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_jump = 1'b0;
  logic       collide = 1'b0;
  logic [1:0] gamestate;
  logic       score_tick, score_clr, jump_pulse;
  logic [3:0] speed_level;

  always #5 clk = ~clk;

  game_ctrl #(.TICK_DIV(TD), .TICK_STEP(TS), .TICK_MIN(TM), .DEB_LEN(DL)) dut (
    .clk(clk), .rst(rst), .btn_jump(btn_jump), .collide(collide),
    .gamestate(gamestate), .score_tick(score_tick), .score_clr(score_clr),
    .jump_pulse(jump_pulse), .speed_level(speed_level)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int c; int gs; int lvl; } rec_t;
  rec_t st_q[$];
  int   clr_q[$];
  int   tick_q[$];
  int   jump_q[$];

  // reference model state (values as they stand before the next clock edge)
  int m_st = S_IDLE;
  int m_phase = 0;
  int m_lvl = 0;
`ifdef GAME_SPEEDUP_EN
  int m_nt = 0;
`endif
  bit m_s0 = 0, m_s1 = 0, m_stable = 0, m_stable_q = 0;
  bit win[$];

  function automatic int model_period(input int lvl);
    int p;
    p = TD - lvl * TS;
    return (p < TM) ? TM : p;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_pulse(input string nm, input logic p, input int have, input int front,
                           output bit popit);
    popit = 1'b0;
    if (have != 0 && front < cyc) begin
      checks++; failures++; popit = 1'b1;
      $display("FAIL %s: no pulse seen for cycle %0d, required 1", nm, front);
    end else if (p === 1'b1) begin
      checks++;
      if (have != 0 && front == cyc) popit = 1'b1;
      else begin
        failures++;
        $display("FAIL %s: got 1 in cycle %0d, required 0", nm, cyc);
      end
    end else if (have != 0 && front == cyc) begin
      checks++; failures++; popit = 1'b1;
      $display("FAIL %s: got %b in cycle %0d, required 1", nm, p, cyc);
    end
  endtask

  always @(posedge clk) begin : model
    bit press, synced, all_diff, clr, tick, jump;
    int nst, per, gs_out;
    cyc++;
    if (!rst) begin
      m_st = S_IDLE; m_phase = 0; m_lvl = 0;
`ifdef GAME_SPEEDUP_EN
      m_nt = 0;
`endif
      m_s0 = 0; m_s1 = 0; m_stable = 0; m_stable_q = 0;
      win.delete();
      st_q.push_back('{cyc, 0, 0});
    end else begin
      press = m_stable && !m_stable_q;
      if (m_st == S_RUN) nst = collide ? S_DEAD : S_RUN;
      else if (press)    nst = S_RUN;
      else               nst = m_st;
      per  = model_period(m_lvl);
      clr  = (m_st != S_RUN) && (nst == S_RUN);
      tick = (m_st == S_RUN) && (nst == S_RUN) && (m_phase == per - 1);
      jump = press && (m_st == S_RUN) && !collide;
      if (clr)  clr_q.push_back(cyc);
      if (tick) tick_q.push_back(cyc);
      if (jump) jump_q.push_back(cyc);
      m_phase = (m_st == S_RUN && m_phase != per - 1) ? m_phase + 1 : 0;
`ifdef GAME_SPEEDUP_EN
      if (clr) begin
        m_lvl = 0; m_nt = 0;
      end else if (tick) begin
        m_nt++;
        if (m_nt == 100) begin
          m_nt = 0;
          if (m_lvl < 15) m_lvl++;
        end
      end
`endif
      synced = m_s1; m_s1 = m_s0; m_s0 = btn_jump;
      m_stable_q = m_stable;
      win.push_back(synced);
      if (win.size() > DL) void'(win.pop_front());
      if (win.size() == DL) begin
        all_diff = 1'b1;
        foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
        if (all_diff) m_stable = !m_stable;
      end
      gs_out = m_st;
      m_st = nst;
      st_q.push_back('{cyc, gs_out, m_lvl});
    end
  end

  always @(negedge clk) begin : monitor
    rec_t r;
    bit pp;
    if (st_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL gamestate: got %0d with no expectation queued in cycle %0d", gamestate, cyc);
    end else begin
      r = st_q.pop_front();
      check("gamestate", 32'(gamestate), 32'(r.gs));
      check("speed_level", 32'(speed_level), 32'(r.lvl));
    end
    chk_pulse("score_clr", score_clr, clr_q.size(), (clr_q.size() != 0) ? clr_q[0] : 0, pp);
    if (pp) void'(clr_q.pop_front());
    chk_pulse("score_tick", score_tick, tick_q.size(), (tick_q.size() != 0) ? tick_q[0] : 0, pp);
    if (pp) void'(tick_q.pop_front());
    chk_pulse("jump_pulse", jump_pulse, jump_q.size(), (jump_q.size() != 0) ? jump_q[0] : 0, pp);
    if (pp) void'(jump_q.pop_front());
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  initial begin
    int run_left;
    bit pat [7];
    pat = '{1, 1, 0, 0, 1, 1, 0};
    run_left = 0;
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();

    // short bounces never survive the debouncer
    foreach (pat[i]) begin
      btn_jump = pat[i];
      step();
    end
    repeat (12) step();
    check("bounce_idle", 32'(gamestate), 32'(S_IDLE));

    // held press starts a game
    btn_jump = 1'b1;
    repeat (10) step();
    btn_jump = 1'b0;
    repeat (40) step();
    check("run_after_press", 32'(gamestate), 32'(S_RUN));

    // press and collide reaching the FSM in the same cycle
    btn_jump = 1'b1;
    repeat (6) step();
    collide = 1'b1;
    step();
    collide = 1'b0;
    btn_jump = 1'b0;
    repeat (15) step();
    check("dead_after_collide", 32'(gamestate), 32'(S_DEAD));

    // restart from DEAD
    btn_jump = 1'b1;
    repeat (10) step();
    btn_jump = 1'b0;
    repeat (25) step();
    check("run_after_restart", 32'(gamestate), 32'(S_RUN));

    // asynchronous reset mid-game
    rst = 1'b0;
    #1;
    check("async_rst_gamestate", 32'(gamestate), 32'(S_IDLE));
    check("async_rst_speed", 32'(speed_level), 32'(0));
    check("async_rst_pulses", 32'({score_tick, score_clr, jump_pulse}), 32'(0));
    step();
    rst = 1'b1;
    repeat (5) step();
    check("idle_after_rst", 32'(gamestate), 32'(S_IDLE));

`ifdef GAME_SPEEDUP_EN
    btn_jump = 1'b1;
    repeat (10) step();
    btn_jump = 1'b0;
    repeat (7500) step();
    check("speed_saturated", 32'(speed_level), 32'(15));
`endif

    // randomized play with occasional one-cycle resets
    repeat (4000) begin
      if (run_left == 0) begin
        btn_jump = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      collide = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 799) != 0);
      step();
    end

    rst = 1'b1;
    collide = 1'b0;
    btn_jump = 1'b0;
    repeat (5) step();
    check("clr_left", 32'(clr_q.size()), 32'(0));
    check("tick_left", 32'(tick_q.size()), 32'(0));
    check("jump_left", 32'(jump_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5_000_000: clk cycles per score tick at level 0.
REQ-002 SHALL have parameter TICK_STEP, default 250_000: period reduction per speed level.
REQ-003 SHALL have parameter TICK_MIN, default 1_500_000: minimum tick period in cycles.
REQ-004 SHALL have parameter DEB_LEN, default 100_000: cycles the synced button must be stable before it is accepted.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-007 SHALL have port btn_jump, input, 1, raw asynchronous push-button, active-high.
REQ-008 SHALL have port collide, input, 1, synchronous collision level from the obstacle logic.
REQ-009 SHALL have port gamestate, output, 2, 00 IDLE, 01 RUN, 10 DEAD.
REQ-010 SHALL have port score_tick, output, 1, one-cycle pulse that drives the score counter's clock input.
REQ-011 SHALL have port score_clr, output, 1, one-cycle pulse that clears the score at game start.
REQ-012 SHALL have port jump_pulse, output, 1, one-cycle pulse per accepted press while in RUN.
REQ-013 SHALL have port speed_level, output, 4, current speed level.

Function
REQ-014 SHALL pass btn_jump through a 2-flop synchronizer, then a debouncer: the stable value flips only after the synced value differs from it for DEB_LEN consecutive cycles; any agreeing cycle restarts the count.
REQ-015 SHALL define "press" as a one-cycle rising edge of the debounced stable value.
REQ-016 SHALL implement FSM transitions:
- IDLE->RUN on press.
- RUN->DEAD on collide=1.
- DEAD->RUN on press.
- Encoding 11 -> IDLE next cycle.
REQ-017 SHALL assert score_clr for exactly the cycle in which the FSM enters RUN; gamestate reads 01 from the following cycle.
REQ-018 SHALL give collide priority over press in RUN: same cycle -> DEAD, no jump_pulse.
REQ-019 SHALL ignore collide outside RUN and ignore press inside RUN for state purposes.
REQ-020 SHALL keep a tick counter that runs only in RUN, is cleared on RUN entry, and is held at 0 outside RUN.
REQ-021 SHALL pulse score_tick when the tick counter equals period-1, wrapping the counter to 0; first tick arrives period cycles after RUN entry.
REQ-022 SHALL not emit score_tick in the cycle the FSM leaves RUN.
REQ-023 SHALL emit jump_pulse one cycle after a press while gamestate=01 and collide=0.
REQ-024 SHALL register all outputs and keep them glitch-free.

Reset
REQ-025 SHALL, while rst=0, force gamestate=00, all pulses 0, speed_level=0, tick/debounce/level counters 0, stable button=0, synchronizer flops 0.
REQ-026 SHALL abort any game on reset mid-RUN; no score_tick or score_clr is emitted during or in the first cycle after reset release.

Configuration
REQ-027 SHALL use macro GAME_SPEEDUP_EN.
- Defined: count score ticks since RUN entry; every 100th tick increments speed_level, saturating at 15; cleared on RUN entry. Period = max(TICK_DIV - speed_level*TICK_STEP, TICK_MIN); a new period takes effect at the next counter wrap.
- Undefined: period = TICK_DIV fixed, speed_level tied 0, no level logic synthesized.

Verification
Bench parameters for all scenarios: TICK_DIV=10, TICK_STEP=2, TICK_MIN=4, DEB_LEN=4.
REQ-028 Reset, then bounce btn_jump 1-0-1 with 2-cycle periods -> no press, gamestate stays 00.
REQ-029 Hold btn_jump for 10 cycles -> single score_clr pulse, gamestate 01, score_tick every 10 cycles, first tick 10 cycles after score_clr.
REQ-030 In RUN, raise collide and a press on the same cycle -> gamestate 10 next cycle, no jump_pulse, no further score_tick.
REQ-031 In DEAD, press -> score_clr pulse, RUN, tick counter restarted from 0.
REQ-032 With GAME_SPEEDUP_EN: run 100 ticks -> speed_level 1, period 8; after 300 ticks -> period floors at 4; speed_level saturates at 15.
REQ-033 Drop rst mid-RUN for 1 cycle -> gamestate 00 asynchronously, no pulses, speed_level 0.
